cp0: RTL and testbench

Coprocessor-0 interrupt/exception controller for the pipelined CPU: the consuming end of every device interrupt line, including the timer's IRQ on HWInt[0]. It holds SR, Cause, EPC and PRId and takes mtc0/mfc0 accesses from the pipeline. It raises IntReq to flush the pipeline and redirect to the handler, and restores state on eret. It sits beside the M stage and sees the committing instruction's PC, branch-delay flag and exception code.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0.sv | 108 ++++++++++
 tb/tb_cp0.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 interrupt/exception
// controller. Holds CP0 register numbers, field bit positions inside SR and
// Cause, the architectural exception codes, and the masks that describe
// which bits of each register can be written.
package cp0_pkg;

  // CP0 register numbers as seen on the 5-bit sel bus
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int unsigned SR_IM_HI = 15;
  localparam int unsigned SR_IM_LO = 10;
  localparam int unsigned SR_EXL   = 1;
  localparam int unsigned SR_IE    = 0;

  // Cause field positions
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

  // Architectural exception codes
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Software-visible bits of SR (IM, EXL, IE); everything else reads 0
  localparam logic [31:0] SR_MASK  = 32'h0000_FC03;
  // EPC is always word aligned
  localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

  // Resulting return address for a faulting/interrupted instruction:
  // a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_target(input logic [31:0] pc,
                                             input logic        bd);
    logic [31:0] addr;
    addr = bd ? (pc - 32'd4) : pc;
    return addr & EPC_MASK;
  endfunction

endpackage

// File: rtl/cp0.sv
// cp0: coprocessor-0 interrupt/exception controller.
// Holds SR, Cause, EPC and PRId, serves mtc0/mfc0 accesses from the M stage,
// raises IntReq to redirect the pipeline to the handler and restores state
// on eret.
//
// Ports:
//   CLK_I    clock, all state changes on posedge
//   RST_I    synchronous active-high reset
//   sel      CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   WE_I     mtc0 write strobe
//   DAT_I    mtc0 write data
//   DAT_O    mfc0 read data, combinational on sel, 0 for unmapped numbers
//   PC       PC of the instruction in M
//   BD       M instruction is in a branch delay slot
//   ExcIn    M instruction raised a synchronous exception
//   ExcCode  exception code accompanying ExcIn
//   HWInt    level-sensitive device interrupt lines (bit 0 = timer)
//   EXLClr   eret commits in M
//   IntReq   take exception/interrupt this cycle
//   EPC_O    current EPC (eret target)
//   ExcVec   handler entry address (constant)
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h0000_4C34,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:0]  sel,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        ExcIn,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_O,
  output logic [31:0] ExcVec
);

  // SR and EPC are kept as full words with their fixed-zero bits masked on
  // every write, so the read path is a plain word select.
  logic [31:0] sr_q;
  logic [31:0] epc_q;
  logic        cause_bd_q;
  logic [5:0]  ip_q;
  logic [4:0]  exc_q;

  logic        int_pend;
  logic        req;
  logic [31:0] cause_word;

  // Live HWInt is used here; the registered IP copy is for reads only.
  assign int_pend = (|(HWInt & sr_q[SR_IM_HI:SR_IM_LO])) & sr_q[SR_IE];
  assign req      = (int_pend | ExcIn) & ~sr_q[SR_EXL] & ~RST_I;

  assign IntReq = req;
  assign EPC_O  = epc_q;
  assign ExcVec = HANDLER;

  assign cause_word = {cause_bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};

  always_comb begin
    DAT_O = '0;
    case (sel)
      REG_SR:    DAT_O = sr_q;
      REG_CAUSE: DAT_O = cause_word;
      REG_EPC:   DAT_O = epc_q;
      REG_PRID:  DAT_O = PRID;
      default:   DAT_O = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sr_q       <= '0;
      epc_q      <= '0;
      cause_bd_q <= 1'b0;
      ip_q       <= '0;
      exc_q      <= '0;
    end else begin
      ip_q <= HWInt;
      if (req) begin
        // Entry: any mtc0 in this cycle is flushed, so writes are not
        // considered at all on this branch.
        sr_q[SR_EXL] <= 1'b1;
        cause_bd_q   <= BD;
        epc_q        <= epc_target(PC, BD);
        exc_q        <= int_pend ? EXC_INT : ExcCode;
      end else begin
        if (WE_I) begin
          case (sel)
            REG_SR:  sr_q  <= DAT_I & SR_MASK;
            REG_EPC: epc_q <= DAT_I & EPC_MASK;
            default: ;
          endcase
        end
        // Placed after the write so eret wins for the EXL bit only.
        if (EXLClr) sr_q[SR_EXL] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: scoreboard bench for cp0. A driver applies one input vector per
// cycle, predicts the cycle's outputs from a word-level reference model and
// queues the prediction; a monitor pops and compares on the falling edge.
module tb_cp0;

  localparam logic [31:0] PRID_V    = 32'h0000_4C34;
  localparam logic [31:0] HANDLER_V = 32'h0000_4180;

  logic        clk;
  logic        RST_I;
  logic [4:0]  sel;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] PC;
  logic        BD;
  logic        ExcIn;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC_O;
  logic [31:0] ExcVec;

  cp0 #(.PRID(PRID_V), .HANDLER(HANDLER_V)) dut (
    .CLK_I(clk), .RST_I(RST_I), .sel(sel), .WE_I(WE_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .PC(PC), .BD(BD), .ExcIn(ExcIn), .ExcCode(ExcCode),
    .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPC_O(EPC_O),
    .ExcVec(ExcVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] dat;
    logic [31:0] epc;
    bit          regs;
    bit          has_k;
    logic [31:0] k;
    int          id;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural registers as whole words
  logic [31:0] m_sr = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc = '0;

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_pend(input logic [5:0] hw);
    logic [31:0] lines;
    lines = {26'b0, hw} << 10;
    return ((lines & m_sr & 32'h0000_FC00) != 32'h0) && m_sr[0];
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h expected %h", nm, id, act, want);
    end
  endtask

  // One clock cycle of stimulus, with prediction and model update
  task automatic cyc(input bit r, input logic [4:0] s, input bit we,
                     input logic [31:0] d, input logic [31:0] pc, input bit bd,
                     input bit exc, input logic [4:0] code,
                     input logic [5:0] hw, input bit clr, input bit regs,
                     input bit hk, input logic [31:0] k, input int id);
    exp_t e;
    bit pend;
    bit rq;
    RST_I = r; sel = s; WE_I = we; DAT_I = d; PC = pc; BD = bd;
    ExcIn = exc; ExcCode = code; HWInt = hw; EXLClr = clr;
    pend = m_pend(hw);
    rq = (pend || exc) && !m_sr[1] && !r;
    e.req = rq; e.dat = m_read(s); e.epc = m_epc; e.regs = regs;
    e.has_k = hk; e.k = k; e.id = id;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_sr = '0; m_cause = '0; m_epc = '0;
    end else if (rq) begin
      m_sr    = m_sr | 32'h2;
      m_cause = ({31'b0, bd} << 31) | ({26'b0, hw} << 10) |
                (pend ? 32'h0 : ({27'b0, code} << 2));
      m_epc   = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, hw} << 10);
      if (we && s == 5'd12) m_sr = d & 32'h0000_FC03;
      if (we && s == 5'd14) m_epc = d & 32'hFFFF_FFFC;
      if (clr) m_sr[1] = 1'b0;
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] s, input logic [5:0] hw, input bit hk,
                    input logic [31:0] k, input int id);
    cyc(0, s, 0, 32'h0, 32'h0, 0, 0, 5'd0, hw, 0, 1, hk, k, id);
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d,
                    input logic [5:0] hw, input bit clr, input int id);
    cyc(0, s, 1, d, 32'h0, 0, 0, 5'd0, hw, clr, 1, 0, 32'h0, id);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("IntReq", e.id, {31'b0, IntReq}, {31'b0, e.req});
      if (e.regs) begin
        chk("DAT_O", e.id, DAT_O, e.dat);
        chk("EPC_O", e.id, EPC_O, e.epc);
        chk("ExcVec", e.id, ExcVec, HANDLER_V);
      end
      if (e.has_k) chk("DAT_O_const", e.id, DAT_O, e.k);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    RST_I = 1'b1; sel = '0; WE_I = 1'b0; DAT_I = '0; PC = '0; BD = 1'b0;
    ExcIn = 1'b0; ExcCode = '0; HWInt = '0; EXLClr = 1'b0;
    @(posedge clk); #1;

    // reset and reset-value reads
    cyc(1, 5'd12, 0, 0, 0, 0, 0, 0, 6'h0, 0, 0, 0, 0, 1);
    cyc(1, 5'd12, 0, 0, 0, 0, 0, 0, 6'h0, 0, 1, 1, 32'h0, 2);
    rd(5'd12, 6'h0, 1, 32'h0, 3);
    rd(5'd13, 6'h0, 1, 32'h0, 4);
    rd(5'd14, 6'h0, 1, 32'h0, 5);
    rd(5'd15, 6'h0, 1, PRID_V, 6);
    rd(5'd13, 6'h1, 1, 32'h0, 7);             // IE=0: no request

    // timer interrupt
    wr(5'd12, 32'h0000_0401, 6'h1, 0, 8);
    cyc(0, 5'd12, 0, 0, 32'h0000_3010, 0, 0, 0, 6'h1, 0, 1, 1, 32'h0000_0401, 9);
    rd(5'd12, 6'h1, 1, 32'h0000_0403, 10);
    rd(5'd13, 6'h1, 1, 32'h0000_0400, 11);
    rd(5'd14, 6'h1, 1, 32'h0000_3010, 12);

    // synchronous exception in a delay slot
    cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, 6'h0, 1, 1, 0, 0, 13);
    cyc(0, 5'd13, 0, 0, 32'h0000_3024, 1, 1, 5'd12, 6'h0, 0, 1, 0, 0, 14);
    rd(5'd13, 6'h0, 1, 32'h8000_0030, 15);
    rd(5'd14, 6'h0, 1, 32'h0000_3020, 16);

    // interrupt beats exception; simultaneous mtc0 EPC discarded
    cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, 6'h0, 1, 1, 0, 0, 17);
    wr(5'd12, 32'h0000_1401, 6'h0, 0, 18);
    cyc(0, 5'd14, 1, 32'hDEAD_0000, 32'h0000_3100, 0, 1, 5'd4, 6'h4, 0, 1, 0, 0, 19);
    rd(5'd13, 6'h4, 1, 32'h0000_1000, 20);
    rd(5'd14, 6'h4, 1, 32'h0000_3100, 21);

    // nested interrupt held off by EXL, taken after eret
    rd(5'd12, 6'h1, 1, 32'h0000_1403, 22);
    cyc(0, 5'd12, 0, 0, 0, 0, 0, 0, 6'h1, 1, 1, 0, 0, 23);
    rd(5'd12, 6'h1, 1, 32'h0000_1401, 24);

    // EPC alignment, ignored writes, unmapped read
    wr(5'd14, 32'h0000_3007, 6'h0, 0, 25);
    rd(5'd14, 6'h0, 1, 32'h0000_3004, 26);
    wr(5'd13, 32'hFFFF_FFFF, 6'h0, 0, 27);
    wr(5'd15, 32'hFFFF_FFFF, 6'h0, 0, 28);
    rd(5'd13, 6'h0, 1, 32'h0, 29);
    rd(5'd15, 6'h0, 1, PRID_V, 30);
    rd(5'd3, 6'h0, 1, 32'h0, 31);

    // reset mid-handler
    cyc(1, 5'd12, 0, 0, 32'h0000_3200, 0, 1, 5'd10, 6'h1, 0, 1, 1, 32'h0000_1403, 32);
    rd(5'd12, 6'h1, 1, 32'h0, 33);

    // eret beats a simultaneous mtc0 to SR for EXL only
    wr(5'd12, 32'h0000_0402, 6'h0, 1, 34);
    rd(5'd12, 6'h0, 1, 32'h0000_0400, 35);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, we, bd, exc, clr;
      logic [4:0] s, code;
      logic [5:0] hw;
      logic [31:0] d, pc;
      r    = ($urandom_range(0, 63) == 0);
      s    = 5'($urandom_range(10, 16));
      we   = ($urandom_range(0, 3) == 0);
      d    = $urandom;
      pc   = $urandom;
      bd   = 1'($urandom_range(0, 1));
      exc  = ($urandom_range(0, 7) == 0);
      code = 5'($urandom_range(0, 31));
      hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h0;
      clr  = m_sr[1] && ($urandom_range(0, 3) == 0);
      cyc(r, s, we, d, pc, bd, exc, code, hw, clr, 1, 0, 32'h0, 100 + i);
    end

    @(negedge clk); #1;
    chk("drain", 0, 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
